// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked, registered ALU with optional iterative multiplier
//
// Purpose:
//   Accepts two WIDTH-bit operands and a 4-bit op code on a valid/ready input
//   channel. Returns a registered result plus zero/carry/overflow flags on a
//   valid/ready output channel. Single-cycle ops have latency 1 from the accept
//   edge. When ALU_PIPE_MUL_EN is defined, op 4'b1000 runs a shift-add
//   multiplier that takes WIDTH cycles. Otherwise op 4'b1000 decodes as add.
//
// Configuration macro:
//   ALU_PIPE_MUL_EN - build the iterative multiplier (MUL state, counter, busy).
//
// Parameters:
//   WIDTH  operand/result width (>= 4)
//   SHW    $clog2(WIDTH), low shift-amount bits (derived)
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   in_valid     in   1      operands/op presented
//   in_ready     out  1      block accepts operands this cycle
//   a            in   WIDTH  source 1
//   b            in   WIDTH  source 2
//   alu_control  in   4      operation select
//   out_valid    out  1      result/flags valid
//   out_ready    in   1      consumer takes the result this cycle
//   result       out  WIDTH  registered result
//   zero         out  1      registered result == 0
//   carry        out  1      registered carry / no-borrow (add/sub only)
//   overflow     out  1      registered signed overflow (add/sub only)
//   busy         out  1      high while a multi-cycle op iterates

module alu_pipe #(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_NOT  = 4'b0010;
    localparam logic [3:0] OP_SHL  = 4'b0011;
    localparam logic [3:0] OP_SHR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1011;

    localparam logic [WIDTH-1:0] WIDTH_VAL = WIDTH[WIDTH-1:0];

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             shift_big;
    logic [SHW-1:0]   shamt;
    logic             lt_signed;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    always_comb begin
        sum_ext   = {1'b0, a} + {1'b0, b};
        diff_ext  = {1'b0, a} - {1'b0, b};
        // The whole of b takes part: any amount >= WIDTH shifts everything out.
        shift_big = (b >= WIDTH_VAL);
        shamt     = b[SHW-1:0];
        lt_signed = ($signed(a) < $signed(b));

        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = 1'b0;
        alu_v   = 1'b0;

        case (alu_control)
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                // Top bit of the extended difference is the borrow.
                alu_c   = ~diff_ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT:  alu_res = ~a;
            OP_SHL:  alu_res = shift_big ? '0 : (a << shamt);
            OP_SHR:  alu_res = shift_big ? '0 : (a >> shamt);
            OP_SRA:  alu_res = shift_big ? {WIDTH{a[WIDTH-1]}}
                                         : WIDTH'($signed(a) >>> shamt);
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt_signed};
            // add, unused codes, and op 1000 when the multiplier is absent
            default: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output-register load selection
    // ------------------------------------------------------------------
    logic             accept;
    logic             load_out;
    logic [WIDTH-1:0] load_res;
    logic             load_c;
    logic             load_v;

    assign accept = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;

    state_t           state;
    logic [SHW-1:0]   count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic             start_mul;
    logic             mul_last;
    logic [WIDTH-1:0] acc_next;

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign start_mul = accept && (alu_control == OP_MUL);
    assign mul_last  = (state == MUL) && (count == SHW'(WIDTH - 1));
    // Partial product for this step; on the last step it is the final product.
    assign acc_next  = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        load_out = (accept && !start_mul) || mul_last;
        load_res = alu_res;
        load_c   = alu_c;
        load_v   = alu_v;
        if (mul_last) begin
            load_res = acc_next;
            load_c   = 1'b0;
            load_v   = 1'b0;
        end
    end

    // Shift-add multiplier: one multiplier bit per cycle, low WIDTH bits kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_mul) begin
                        state  <= MUL;
                        count  <= '0;
                        acc    <= '0;
                        mcand  <= a;
                        mplier <= b;
                        busy   <= 1'b1;
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (mul_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
`else
    assign in_ready = !out_valid || out_ready;
    assign busy     = 1'b0;

    always_comb begin
        load_out = accept;
        load_res = alu_res;
        load_c   = alu_c;
        load_v   = alu_v;
    end
`endif

    // ------------------------------------------------------------------
    // Output register: a new load wins over a drain on the same edge, so
    // out_valid stays high when the consumer and producer both move.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else if (load_out) begin
            result    <= load_res;
            zero      <= (load_res == '0);
            carry     <= load_c;
            overflow  <= load_v;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe

module tb_alu_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  alu_control;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        zero;
    logic        carry;
    logic        overflow;
    logic        busy;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [3:0]  alu_control8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  result8;
    logic        zero8;
    logic        carry8;
    logic        overflow8;
    logic        busy8;

    alu_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_control(alu_control),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .overflow(overflow),
        .busy(busy)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .alu_control(alu_control8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .zero(zero8), .carry(carry8), .overflow(overflow8),
        .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [15:0] va;
        logic [15:0] vb;
        logic [15:0] res;
        logic        z;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs [22];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        logic seen;

        vecs[0]  = '{"add_wrap",   4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{"sub_ovf",    4'b0001, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{"slt",        4'b1011, 16'h7FFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{"sltu",       4'b0111, 16'h7FFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{"shl_4",      4'b0011, 16'h8001, 16'd4,    16'h0010, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"shl_20",     4'b0011, 16'h8001, 16'd20,   16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{"shr_4",      4'b0100, 16'h8001, 16'd4,    16'h0800, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"shr_20",     4'b0100, 16'h8001, 16'd20,   16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{"sra_4",      4'b1001, 16'h8001, 16'd4,    16'hF800, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{"sra_20",     4'b1001, 16'h8001, 16'd20,   16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{"and",        4'b0101, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{"or",         4'b0110, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{"xor_zero",   4'b1010, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{"not",        4'b0010, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{"add_ovf",    4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{"sub_eq",     4'b0001, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{"op1100_add", 4'b1100, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{"op1111_add", 4'b1111, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{"slt_neg",    4'b1011, 16'h8000, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{"sub_borrow", 4'b0001, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{"shl_16",     4'b0011, 16'h0001, 16'd16,   16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[21] = '{"sra_15",     4'b1001, 16'h8000, 16'd15,   16'hFFFF, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; alu_control = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; alu_control8 = '0; out_ready8 = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Traffic, then an asynchronous reset between edges.
        a = 16'd5; b = 16'd6; alu_control = 4'b0000; in_valid = 1'b1;
        step();
        check("pre_reset_result", result, 16'd11);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_result", result, 16'h0);
        check("rst_zero", zero, 1'b0);
        check("rst_carry", carry, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_in_ready", in_ready, 1'b1);

        // Vector table, back to back with out_ready high.
        for (int i = 0; i < 22; i++) begin
            a = vecs[i].va; b = vecs[i].vb; alu_control = vecs[i].op; in_valid = 1'b1;
            if (i == 0) check("add_latency_before", out_valid, 1'b0);
            step();
            check({vecs[i].name, "_valid"}, out_valid, 1'b1);
            check({vecs[i].name, "_result"}, result, vecs[i].res);
            check({vecs[i].name, "_zero"}, zero, vecs[i].z);
            check({vecs[i].name, "_carry"}, carry, vecs[i].c);
            check({vecs[i].name, "_overflow"}, overflow, vecs[i].v);
        end
        in_valid = 1'b0;
        step();
        check("drain_out_valid", out_valid, 1'b0);

        // Backpressure: second request stalls until the first drains.
        out_ready = 1'b0;
        a = 16'd1; b = 16'd2; alu_control = 4'b0000; in_valid = 1'b1;
        step();
        check("bp_first_result", result, 16'd3);
        a = 16'd10; b = 16'd20;
        check("bp_in_ready_low", in_ready, 1'b0);
        step();
        check("bp_held_result", result, 16'd3);
        check("bp_held_valid", out_valid, 1'b1);
        check("bp_still_stalled", in_ready, 1'b0);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", in_ready, 1'b1);
        step();
        check("bp_second_result", result, 16'd30);
        check("bp_second_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        step();
        check("bp_drained", out_valid, 1'b0);

`ifdef ALU_PIPE_MUL_EN
        a = 16'd300; b = 16'd300; alu_control = 4'b1000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("mul_busy_start", busy, 1'b1);
        check("mul_in_ready_start", in_ready, 1'b0);
        check("mul_no_valid_start", out_valid, 1'b0);
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            step();
            if (k == 8) begin
                check("mul_busy_mid", busy, 1'b1);
                check("mul_in_ready_mid", in_ready, 1'b0);
            end
            if (out_valid) lat = k;
        end
        check("mul_latency", lat, 16);
        check("mul_result", result, 16'h5F90);
        check("mul_busy_done", busy, 1'b0);
        check("mul_carry", carry, 1'b0);
        step();

        a = 16'd300; b = 16'd300; alu_control = 4'b1000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        rst_n = 1'b0;
        #1;
        check("mul_abort_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (24) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check("mul_abort_no_valid", seen, 1'b0);
`else
        a = 16'd3; b = 16'd4; alu_control = 4'b1000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("op1000_valid", out_valid, 1'b1);
        check("op1000_result", result, 16'd7);
        check("op1000_busy", busy, 1'b0);
        step();
`endif

        // WIDTH=8 instance.
        a8 = 8'hFF; b8 = 8'h01; alu_control8 = 4'b0000; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        check("w8_valid", out_valid8, 1'b1);
        check("w8_result", result8, 8'h00);
        check("w8_carry", carry8, 1'b1);
        check("w8_zero", zero8, 1'b1);
        check("w8_overflow", overflow8, 1'b0);
        check("w8_busy", busy8, 1'b0);
        check("w8_in_ready", in_ready8, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
